id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; legal values 32, 16 (RV32E).
REQ-003 SHALL have ports, one clock, reset synchronous and active-high:
  clk  input  1  clock, all state on rising edge
  rst  input  1  synchronous active-high reset
  in_valid  input  1  fetch offers instruction
  in_ready  output  1  stage accepts this cycle
  in_instr  input  32  instruction word
  in_pc  input  XLEN  instruction address
  flush  input  1  kill held and offered instruction
  wb_en  input  1  writeback enable
  wb_rd  input  5  writeback destination
  wb_data  input  XLEN  writeback value
  ex_load  input  1  EX-stage instruction is a load
  ex_rd  input  5  EX-stage destination
  out_valid  output  1  ID/EX register holds instruction
  out_ready  input  1  EX accepts
  out_ctrl  output  CTRL_W  packed ctrl_t control word
  out_rs1_data, out_rs2_data  output  XLEN  operands
  out_imm  output  XLEN  selected immediate, sign-extended
  out_pc  output  XLEN  registered in_pc
  out_rd, out_rs1, out_rs2  output  5  register indices
  out_illegal  output  1  undecodable instruction

Function
REQ-004 SHALL decode RV32I opcodes into ctrl_t (alu_op, imm_sel, op_a_sel, op_b_sel, load, store, branch, jal, jalr, reg_write, mem_to_reg) in the same cycle as acceptance.
REQ-005 SHALL generate I/S/B/U/J immediates sign-extended from instr[31] to XLEN.
REQ-006 SHALL keep an internal register file of NREGS x XLEN; x0 reads 0, writes to x0 ignored.
REQ-007 SHALL set out_illegal=1, reg_write=0, store=0 for unknown opcode, or any used index >= NREGS.
REQ-008 SHALL implement ID/EX register as two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-009 SHALL compute hazard = in_valid & ex_load & ex_rd!=0 & (ex_rd==rs1 used | ex_rd==rs2 used); rs "used" per opcode.
REQ-010 SHALL drive in_ready = !flush & !hazard & (EMPTY | out_ready), combinationally.
REQ-011 SHALL load ID/EX register when in_valid & in_ready; latency one cycle; state FULL.
REQ-012 SHALL go EMPTY when FULL & out_ready & no new accept (bubble on load-use).
REQ-013 SHALL hold all outputs stable while FULL & !out_ready.
REQ-014 SHALL, on flush, go EMPTY next cycle, discarding held and offered instruction; flush beats accept and hazard.
REQ-015 SHALL perform regfile write on wb_en regardless of flush, stall or state.

Reset
REQ-016 SHALL, while rst=1 at clk edge, clear out_valid, all out_* registers, and every register-file entry to 0.
REQ-017 SHALL hold in_ready=0 during the reset cycle.

Configuration
REQ-018 SHALL, with ID_WB_BYPASS_EN defined, return wb_data for a read where wb_en & wb_rd==rs & rs!=0 (write-through, same cycle).
REQ-019 SHALL, without ID_WB_BYPASS_EN, add that match condition to hazard (one-cycle stall until the write has landed).

Structure
REQ-020 SHALL place ctrl_t, CTRL_W, alu_op enum, imm_sel enum and opcode constants in shared package id_pkg.
REQ-021 SHALL instantiate register file as sub-module id_regfile (parameters XLEN, NREGS; 2 read, 1 write port).

Verification
REQ-022 Reset then ADDI x1,x0,5 offered, out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, reg_write=1.
REQ-023 ex_load=1, ex_rd=3, offered ADD x4,x3,x2 -> in_ready=0 one cycle, out_valid=0 next; accepted after ex_load drops.
REQ-024 wb_en=1, wb_rd=2, wb_data=0xDEAD, offered ADD x5,x2,x0 -> with macro out_rs1_data=0xDEAD, no stall; without macro one stall cycle then 0xDEAD.
REQ-025 FULL, out_ready=0 for 3 cycles, flush pulse in cycle 2 -> outputs stable cycle 1, out_valid=0 after flush, offered instruction not captured.
REQ-026 NREGS=16, offered ADD x17,x1,x2 -> out_illegal=1, reg_write=0; XLEN=64 LUI x1,0x80000 -> out_imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU/immediate selectors, control word.
package id_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  localparam logic [1:0] OPA_RS1  = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd1;
  localparam logic [1:0] OPA_ZERO = 2'd2;
  localparam logic       OPB_RS2  = 1'b0;
  localparam logic       OPB_IMM  = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    alu_op_e    alu_op;
    imm_sel_e   imm_sel;
    logic [1:0] op_a_sel;
    logic       op_b_sel;
    logic       load;
    logic       store;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef struct packed {
    ctrl_t ctrl;
    logic  rs1_used;
    logic  rs2_used;
    logic  known;
  } dec_t;

  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    d.ctrl.alu_op   = ALU_ADD;
    d.ctrl.imm_sel  = IMM_NONE;
    d.ctrl.op_a_sel = OPA_RS1;
    d.ctrl.op_b_sel = OPB_RS2;
    d.known         = 1'b1;
    case (instr[6:0])
      OPC_LUI: begin
        d.ctrl.imm_sel = IMM_U; d.ctrl.op_a_sel = OPA_ZERO; d.ctrl.op_b_sel = OPB_IMM;
        d.ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        d.ctrl.imm_sel = IMM_U; d.ctrl.op_a_sel = OPA_PC; d.ctrl.op_b_sel = OPB_IMM;
        d.ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        d.ctrl.imm_sel = IMM_J; d.ctrl.op_a_sel = OPA_PC; d.ctrl.op_b_sel = OPB_IMM;
        d.ctrl.jal = 1'b1; d.ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        d.ctrl.imm_sel = IMM_I; d.ctrl.op_b_sel = OPB_IMM;
        d.ctrl.jalr = 1'b1; d.ctrl.reg_write = 1'b1; d.rs1_used = 1'b1;
      end
      OPC_BRANCH: begin
        d.ctrl.alu_op = ALU_SUB; d.ctrl.imm_sel = IMM_B; d.ctrl.branch = 1'b1;
        d.rs1_used = 1'b1; d.rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        d.ctrl.imm_sel = IMM_I; d.ctrl.op_b_sel = OPB_IMM; d.ctrl.load = 1'b1;
        d.ctrl.reg_write = 1'b1; d.ctrl.mem_to_reg = 1'b1; d.rs1_used = 1'b1;
      end
      OPC_STORE: begin
        d.ctrl.imm_sel = IMM_S; d.ctrl.op_b_sel = OPB_IMM; d.ctrl.store = 1'b1;
        d.rs1_used = 1'b1; d.rs2_used = 1'b1;
      end
      OPC_OPIMM: begin
        d.ctrl.alu_op = alu_from_funct(instr[14:12], instr[30], 1'b0);
        d.ctrl.imm_sel = IMM_I; d.ctrl.op_b_sel = OPB_IMM;
        d.ctrl.reg_write = 1'b1; d.rs1_used = 1'b1;
      end
      OPC_OP: begin
        d.ctrl.alu_op = alu_from_funct(instr[14:12], instr[30], 1'b1);
        d.ctrl.reg_write = 1'b1; d.rs1_used = 1'b1; d.rs2_used = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file: 2 combinational read ports, 1 write port, x0 hardwired to zero.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs_q [NREGS];

  function automatic logic in_range(input logic [4:0] a);
    return int'(a) < NREGS;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && waddr != 5'd0 && in_range(waddr)) begin
      regs_q[waddr[AW-1:0]] <= wdata;
    end
  end

  // Out-of-range indices read as zero; the decoder flags them illegal anyway.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0 && in_range(raddr1)) rdata1 = regs_q[raddr1[AW-1:0]];
    if (raddr2 != 5'd0 && in_range(raddr2)) rdata2 = regs_q[raddr2[AW-1:0]];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with register file and a valid/ready ID/EX register.
// Optional macro ID_WB_BYPASS_EN: forward same-cycle writeback data instead of stalling.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_load,
  input  logic [4:0]        ex_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic              out_illegal
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  dec_t                   dec;
  logic [4:0]             rs1, rs2, rd;
  logic                   illegal_d;
  ctrl_t                  ctrl_d;
  logic signed [31:0]     imm32;
  logic [XLEN-1:0]        imm_d, rf_rd1, rf_rd2, rs1_data_d, rs2_data_d;
  logic                   load_use, wb_hazard, hazard, accept;
  logic [0:0]             state_q, state_d;

  ctrl_t                  ctrl_q;
  logic [XLEN-1:0]        rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic [4:0]             rd_q, rs1_q, rs2_q;
  logic                   illegal_q;

  assign dec = decode(in_instr);
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  always_comb begin
    illegal_d = !dec.known
             || (dec.rs1_used && int'(rs1) >= NREGS)
             || (dec.rs2_used && int'(rs2) >= NREGS)
             || (dec.ctrl.reg_write && int'(rd) >= NREGS);
    ctrl_d = dec.ctrl;
    if (illegal_d) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.store     = 1'b0;
    end
  end

  always_comb begin
    imm32 = '0;
    case (dec.ctrl.imm_sel)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed source widens by sign extension when XLEN is 64.
  assign imm_d = XLEN'(imm32);

  id_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2)
  );

`ifdef ID_WB_BYPASS_EN
  assign rs1_data_d = (wb_en && wb_rd == rs1 && rs1 != 5'd0) ? wb_data : rf_rd1;
  assign rs2_data_d = (wb_en && wb_rd == rs2 && rs2 != 5'd0) ? wb_data : rf_rd2;
  assign wb_hazard  = 1'b0;
`else
  assign rs1_data_d = rf_rd1;
  assign rs2_data_d = rf_rd2;
  assign wb_hazard  = wb_en && wb_rd != 5'd0
                   && ((dec.rs1_used && wb_rd == rs1) || (dec.rs2_used && wb_rd == rs2));
`endif

  assign load_use = ex_load && ex_rd != 5'd0
                 && ((dec.rs1_used && ex_rd == rs1) || (dec.rs2_used && ex_rd == rs2));
  assign hazard   = in_valid && (load_use || wb_hazard);
  assign in_ready = !rst && !flush && !hazard && (state_q == S_EMPTY || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (flush)                              state_d = S_EMPTY;
    else if (accept)                        state_d = S_FULL;
    else if (state_q == S_FULL && out_ready) state_d = S_EMPTY;
  end

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      ctrl_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q     <= ctrl_d;
        rs1_data_q <= rs1_data_d;
        rs2_data_q <= rs2_data_d;
        imm_q      <= imm_d;
        pc_q       <= in_pc;
        rd_q       <= rd;
        rs1_q      <= rs1;
        rs2_q      <= rs2;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign out_valid    = (state_q == S_FULL);
  assign out_ctrl     = ctrl_q;
  assign out_rs1_data = rs1_data_q;
  assign out_rs2_data = rs2_data_q;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: default instance plus an XLEN=64 / NREGS=16 instance on shared stimulus.
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_en, ex_load, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, wb_data;
  logic [4:0]  wb_rd, ex_rd;

  logic              a_in_ready, a_out_valid, a_ill;
  logic [CTRL_W-1:0] a_ctrl;
  logic [31:0]       a_rs1d, a_rs2d, a_imm, a_pc;
  logic [4:0]        a_rd, a_rs1, a_rs2;

  logic              b_in_ready, b_out_valid, b_ill;
  logic [CTRL_W-1:0] b_ctrl;
  logic [63:0]       b_rs1d, b_rs2d, b_imm, b_pc;
  logic [4:0]        b_rd, b_rs1, b_rs2;

  ctrl_t ca, cb;
  assign ca = ctrl_t'(a_ctrl);
  assign cb = ctrl_t'(b_ctrl);

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI_X1_X0_5 = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X4_X3_X2 = 32'h0021_8233;
  localparam logic [31:0] I_ADD_X5_X2_X0 = 32'h0001_02B3;
  localparam logic [31:0] I_SW_X2_8_X1   = 32'h0020_A423;
  localparam logic [31:0] I_BEQ_M4       = 32'hFE00_0EE3;
  localparam logic [31:0] I_BAD          = 32'hFFFF_FFFF;
  localparam logic [31:0] I_ADD_X17      = 32'h0020_88B3;
  localparam logic [31:0] I_LUI_X1       = 32'h8000_00B7;
  localparam logic [31:0] I_ADD_X7_X6_X0 = 32'h0003_03B3;

  id_stage_pipe #(.XLEN(32), .NREGS(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
    .ex_load(ex_load), .ex_rd(ex_rd), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_ctrl), .out_rs1_data(a_rs1d), .out_rs2_data(a_rs2d), .out_imm(a_imm),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_illegal(a_ill)
  );

  id_stage_pipe #(.XLEN(64), .NREGS(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_load(ex_load), .ex_rd(ex_rd), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_ctrl), .out_rs1_data(b_rs1d), .out_rs2_data(b_rs2d), .out_imm(b_imm),
    .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_illegal(b_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_instr = I_ADDI_X1_X0_5; in_pc = 64'h0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'h0;
    ex_load = 1'b0; ex_rd = 5'd0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc(); cyc();
    chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
    chk("rst_out_imm", {32'b0, a_imm}, 64'd0);
    chk("rst_out_rd", {59'b0, a_rd}, 64'd0);
    chk("rst_out_ctrl", {{(64-CTRL_W){1'b0}}, a_ctrl}, 64'd0);
    chk("rst_out_pc", {32'b0, a_pc}, 64'd0);

    // ADDI x1,x0,5
    rst = 1'b0; in_pc = 64'h100;
    #1 chk("addi_in_ready", {63'b0, a_in_ready}, 64'd1);
    cyc();
    chk("addi_valid", {63'b0, a_out_valid}, 64'd1);
    chk("addi_imm", {32'b0, a_imm}, 64'd5);
    chk("addi_rd", {59'b0, a_rd}, 64'd1);
    chk("addi_rw", {63'b0, ca.reg_write}, 64'd1);
    chk("addi_alu", {60'b0, ca.alu_op}, {60'b0, ALU_ADD});
    chk("addi_opb", {63'b0, ca.op_b_sel}, {63'b0, OPB_IMM});
    chk("addi_pc", {32'b0, a_pc}, 64'h100);
    chk("addi_illegal", {63'b0, a_ill}, 64'd0);

    // Load-use stall
    ex_load = 1'b1; ex_rd = 5'd3; in_instr = I_ADD_X4_X3_X2; in_pc = 64'h104;
    #1 chk("lu_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc();
    chk("lu_bubble", {63'b0, a_out_valid}, 64'd0);
    ex_load = 1'b0;
    #1 chk("lu_release", {63'b0, a_in_ready}, 64'd1);
    cyc();
    chk("lu_valid", {63'b0, a_out_valid}, 64'd1);
    chk("lu_rd", {59'b0, a_rd}, 64'd4);
    chk("lu_rs1", {59'b0, a_rs1}, 64'd3);
    chk("lu_rs2", {59'b0, a_rs2}, 64'd2);

    // Writeback to x2 while ADD x5,x2,x0 is offered
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 64'hDEAD; in_instr = I_ADD_X5_X2_X0; in_pc = 64'h108;
`ifdef ID_WB_BYPASS_EN
    #1 chk("wb_in_ready", {63'b0, a_in_ready}, 64'd1);
    cyc();
    wb_en = 1'b0;
`else
    #1 chk("wb_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc();
    wb_en = 1'b0;
    chk("wb_stall", {63'b0, a_out_valid}, 64'd0);
    #1 chk("wb_release", {63'b0, a_in_ready}, 64'd1);
    cyc();
`endif
    chk("wb_valid", {63'b0, a_out_valid}, 64'd1);
    chk("wb_rs1_data", {32'b0, a_rs1d}, 64'hDEAD);
    chk("wb_rs2_data", {32'b0, a_rs2d}, 64'd0);
    chk("wb_rd", {59'b0, a_rd}, 64'd5);

    // Backpressure then flush
    out_ready = 1'b0; in_instr = I_SW_X2_8_X1; in_pc = 64'h10C;
    #1 chk("bp_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc();
    chk("bp_valid", {63'b0, a_out_valid}, 64'd1);
    chk("bp_rd_hold", {59'b0, a_rd}, 64'd5);
    chk("bp_data_hold", {32'b0, a_rs1d}, 64'hDEAD);
    flush = 1'b1;
    #1 chk("fl_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc();
    chk("fl_valid", {63'b0, a_out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl_still_empty", {63'b0, a_out_valid}, 64'd0);
    chk("fl_rd_not_captured", {59'b0, a_rd}, 64'd5);
    chk("fl_imm_not_captured", {32'b0, a_imm}, 64'd0);

    // SW x2,8(x1)
    in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk("sw_valid", {63'b0, a_out_valid}, 64'd1);
    chk("sw_imm", {32'b0, a_imm}, 64'd8);
    chk("sw_store", {63'b0, ca.store}, 64'd1);
    chk("sw_rw", {63'b0, ca.reg_write}, 64'd0);
    chk("sw_rs1_data", {32'b0, a_rs1d}, 64'd0);
    chk("sw_rs2_data", {32'b0, a_rs2d}, 64'hDEAD);

    // BEQ x0,x0,-4
    in_instr = I_BEQ_M4;
    cyc();
    chk("beq_imm", {32'b0, a_imm}, 64'hFFFF_FFFC);
    chk("beq_branch", {63'b0, ca.branch}, 64'd1);
    chk("beq_alu", {60'b0, ca.alu_op}, {60'b0, ALU_SUB});

    // Unknown opcode
    in_instr = I_BAD;
    cyc();
    chk("bad_illegal", {63'b0, a_ill}, 64'd1);
    chk("bad_rw", {63'b0, ca.reg_write}, 64'd0);
    chk("bad_store", {63'b0, ca.store}, 64'd0);

    // ADD x17,x1,x2: legal with 32 regs, illegal with 16
    in_instr = I_ADD_X17;
    cyc();
    chk("x17_a_illegal", {63'b0, a_ill}, 64'd0);
    chk("x17_a_rd", {59'b0, a_rd}, 64'd17);
    chk("x17_a_rw", {63'b0, ca.reg_write}, 64'd1);
    chk("x17_b_illegal", {63'b0, b_ill}, 64'd1);
    chk("x17_b_rw", {63'b0, cb.reg_write}, 64'd0);

    // LUI x1,0x80000
    in_instr = I_LUI_X1;
    cyc();
    chk("lui_a_imm", {32'b0, a_imm}, 64'h8000_0000);
    chk("lui_b_imm", b_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_opa", {62'b0, ca.op_a_sel}, {62'b0, OPA_ZERO});

    // Flush beats accept; writeback lands regardless of flush
    in_instr = I_ADDI_X1_X0_5; flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd6; wb_data = 64'h77;
    #1 chk("fl2_in_ready", {63'b0, a_in_ready}, 64'd0);
    cyc();
    chk("fl2_valid", {63'b0, a_out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; wb_rd = 5'd0; wb_data = 64'h1234;
    cyc();
    wb_en = 1'b0; in_valid = 1'b1; in_instr = I_ADD_X7_X6_X0;
    #1 chk("x6_in_ready", {63'b0, a_in_ready}, 64'd1);
    cyc();
    chk("x6_a_rs1_data", {32'b0, a_rs1d}, 64'h77);
    chk("x0_a_rs2_data", {32'b0, a_rs2d}, 64'd0);
    chk("x6_b_rs1_data", b_rs1d, 64'h77);
    chk("x6_rd", {59'b0, a_rd}, 64'd7);

    in_valid = 1'b0;
    cyc();
    chk("drain_valid", {63'b0, a_out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
